// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store alignment unit.
//   - RV32I funct3 width/sign codes used by loads and stores
//   - FSM state encoding (IDLE / SECOND)
//   - lane_mask(): byte-lane mask of an access before lane shifting
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] SECOND = 1'b1;

  // Unshifted byte-lane mask for a given width code; unknown codes touch nothing.
  function automatic logic [3:0] lane_mask(input logic [2:0] f3);
    logic [3:0] m;
    case (f3)
      F3_B, F3_BU: m = 4'b0001;
      F3_H, F3_HU: m = 4'b0011;
      F3_W:        m = 4'b1111;
      default:     m = 4'b0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/lsu_align_unit_load_extend.sv
// load_extend: combinational load data path.
//   Shifts the addressed bytes of a memory word down to lane 0, or in the
//   second half of a split load merges the held low part with the low lanes
//   of the second word, then sign/zero-extends according to funct3.
// Ports:
//   funct3   in  load width/sign code
//   off      in  byte offset within the first word
//   second   in  1 = second half of a split load (merge with lo_hold)
//   rdata    in  memory read data of the word currently addressed
//   lo_hold  in  bytes kept from the first word of a split load
//   lo_part  out rdata shifted down by off (captured as lo_hold)
//   result   out extended load result
module load_extend
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic        second,
  input  logic [31:0] rdata,
  input  logic [31:0] lo_hold,
  output logic [31:0] lo_part,
  output logic [31:0] result
);

  logic [31:0] upper_s;
  logic [31:0] merged_s;

  // Align bytes to lane 0, merge split halves and extend.
  always_comb begin
    lo_part = rdata >> {off, 3'b000};
    // Low lanes of the second word land just above the bytes taken from the first.
    if (off == 2'd0) begin
      upper_s = 32'h0000_0000;
    end else begin
      upper_s = rdata << (6'd32 - {1'b0, off, 3'b000});
    end
    if (second) begin
      merged_s = lo_hold | upper_s;
    end else begin
      merged_s = lo_part;
    end
    case (funct3)
      F3_B:    result = {{24{merged_s[7]}}, merged_s[7:0]};
      F3_H:    result = {{16{merged_s[15]}}, merged_s[15:0]};
      F3_W:    result = merged_s;
      F3_BU:   result = {24'h00_0000, merged_s[7:0]};
      F3_HU:   result = {16'h0000, merged_s[15:0]};
      default: result = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/lsu_align_unit.sv
// lsu_align_unit: load/store alignment between EX/MEM and a word-organised
// data memory (64 x 32 bit, word addressed, combinational read).
//   Converts byte addresses into word address, byte enables and lane-shifted
//   write data; splits word-crossing accesses into two word accesses with a
//   one-cycle stall; registers extended load results into MEM/WB.
// Ports:
//   clk, rst                        clock, async active-high reset
//   req_valid, mem_read, mem_write  request qualifiers (store wins over load)
//   funct3, byte_addr, store_data   access code, byte address, rs2 value
//   dm_addr, dm_re, dm_we, dm_be,
//   dm_wdata, dm_rdata              data memory interface
//   stall                           hold upstream pipeline for split access
//   load_data, load_valid           registered load result
//   misalign_trap                   only with LSU_MISALIGN_TRAP_EN defined:
//                                   crossing accesses trap instead of splitting
module lsu_align_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int WORD_AW = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  input  logic               mem_read,
  input  logic               mem_write,
  input  logic [2:0]         funct3,
  input  logic [ADDR_W-1:0]  byte_addr,
  input  logic [31:0]        store_data,
  output logic [WORD_AW-1:0] dm_addr,
  output logic               dm_re,
  output logic               dm_we,
  output logic [3:0]         dm_be,
  output logic [31:0]        dm_wdata,
  input  logic [31:0]        dm_rdata,
  output logic               stall,
  output logic [31:0]        load_data,
`ifdef LSU_MISALIGN_TRAP_EN
  output logic               load_valid,
  output logic               misalign_trap
`else
  output logic               load_valid
`endif
);

  logic [0:0]         state_r;
  logic [0:0]         state_nxt_s;
  logic [31:0]        lo_hold_r;
  logic [31:0]        load_data_r;
  logic               load_valid_r;
  logic [1:0]         off_s;
  logic [WORD_AW-1:0] w0_s;
  logic [WORD_AW-1:0] w1_s;
  logic               is_st_s;
  logic               is_ld_s;
  logic               st_ok_s;
  logic               cross_code_s;
  logic               cross_s;
  logic [7:0]         mask_wide_s;
  logic [63:0]        wdata_wide_s;
  logic               lv_nxt_s;
  logic               cap_lo_s;
  logic               trap_nxt_s;
  logic [31:0]        lo_part_s;
  logic [31:0]        ext_s;

  assign off_s   = byte_addr[1:0];
  assign w0_s    = byte_addr[ADDR_W-1:2];
  // Natural wrap of the word-address width takes word 63 to word 0.
  assign w1_s    = w0_s + {{(WORD_AW-1){1'b0}}, 1'b1};
  assign is_st_s = req_valid & mem_write;
  assign is_ld_s = req_valid & mem_read & ~mem_write;
  assign st_ok_s = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);

  // Width codes that spill past lane 3 at this offset; stores with codes
  // that never write cannot cross.
  assign cross_code_s = (((funct3 == F3_H) || (funct3 == F3_HU)) && (off_s == 2'd3)) ||
                        ((funct3 == F3_W) && (off_s != 2'd0));
  assign cross_s      = (is_ld_s | (is_st_s & st_ok_s)) & cross_code_s;

  // Bits [7:4] / [63:32] are what spills into the following word.
  assign mask_wide_s  = {4'b0000, lane_mask(funct3)} << off_s;
  assign wdata_wide_s = {32'h0000_0000, store_data} << {off_s, 3'b000};

  load_extend u_load_extend (
    .funct3  (funct3),
    .off     (off_s),
    .second  (state_r == SECOND),
    .rdata   (dm_rdata),
    .lo_hold (lo_hold_r),
    .lo_part (lo_part_s),
    .result  (ext_s)
  );

  // Next-state and memory-interface decode; everything idle while in reset.
  always_comb begin
    state_nxt_s = state_r;
    dm_addr     = w0_s;
    dm_re       = 1'b0;
    dm_we       = 1'b0;
    dm_be       = 4'b0000;
    dm_wdata    = wdata_wide_s[31:0];
    stall       = 1'b0;
    lv_nxt_s    = 1'b0;
    cap_lo_s    = 1'b0;
    trap_nxt_s  = 1'b0;
    if (rst) begin
      state_nxt_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (cross_s) begin
`ifdef LSU_MISALIGN_TRAP_EN
            trap_nxt_s = 1'b1;
`else
            stall       = 1'b1;
            state_nxt_s = SECOND;
            if (is_st_s) begin
              dm_we = 1'b1;
              dm_be = mask_wide_s[3:0];
            end else begin
              dm_re    = 1'b1;
              cap_lo_s = 1'b1;
            end
`endif
          end else if (is_st_s) begin
            dm_we = st_ok_s;
            dm_be = st_ok_s ? mask_wide_s[3:0] : 4'b0000;
          end else if (is_ld_s) begin
            dm_re    = 1'b1;
            lv_nxt_s = 1'b1;
          end else begin
            state_nxt_s = IDLE;
          end
        end
`ifndef LSU_MISALIGN_TRAP_EN
        SECOND: begin
          dm_addr     = w1_s;
          state_nxt_s = IDLE;
          if (is_st_s && st_ok_s) begin
            dm_we    = 1'b1;
            dm_be    = mask_wide_s[7:4];
            dm_wdata = wdata_wide_s[63:32];
          end else if (is_ld_s) begin
            dm_re    = 1'b1;
            lv_nxt_s = 1'b1;
          end else begin
            state_nxt_s = IDLE;
          end
        end
`endif
        default: state_nxt_s = IDLE;
      endcase
    end
  end

  // State, split-load holding register and MEM/WB load result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      lo_hold_r    <= 32'h0000_0000;
      load_data_r  <= 32'h0000_0000;
      load_valid_r <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      load_valid_r <= lv_nxt_s;
      if (cap_lo_s) begin
        lo_hold_r <= lo_part_s;
      end
      if (lv_nxt_s) begin
        load_data_r <= ext_s;
      end
    end
  end

  assign load_data  = load_data_r;
  assign load_valid = load_valid_r;

`ifdef LSU_MISALIGN_TRAP_EN
  logic misalign_trap_r;

  // One-cycle trap pulse for a crossing access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      misalign_trap_r <= 1'b0;
    end else begin
      misalign_trap_r <= trap_nxt_s;
    end
  end

  assign misalign_trap = misalign_trap_r;
`endif

endmodule

// File: tb/tb_lsu_align_unit.sv
// Self-checking bench for lsu_align_unit (default build, splitting enabled).
// Directed cases for the documented scenarios, then randomized accesses
// checked against a byte-addressed reference memory and a width/sign model.
module tb_lsu_align_unit;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  funct3;
  logic [7:0]  byte_addr;
  logic [31:0] store_data;
  logic [5:0]  dm_addr;
  logic        dm_re;
  logic        dm_we;
  logic [3:0]  dm_be;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        stall;
  logic [31:0] load_data;
  logic        load_valid;

  int n_cmp;
  int n_bad;

  logic [31:0] mem [0:63];
  logic [7:0]  ref_mem [0:255];
  logic        poke_en;
  logic [5:0]  poke_addr;
  logic [31:0] poke_val;
  logic [31:0] last_ld;

  lsu_align_unit dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .funct3     (funct3),
    .byte_addr  (byte_addr),
    .store_data (store_data),
    .dm_addr    (dm_addr),
    .dm_re      (dm_re),
    .dm_we      (dm_we),
    .dm_be      (dm_be),
    .dm_wdata   (dm_wdata),
    .dm_rdata   (dm_rdata),
    .stall      (stall),
    .load_data  (load_data),
    .load_valid (load_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory: combinational read, byte-enabled write on the clock edge.
  always_comb dm_rdata = mem[dm_addr];

  always @(posedge clk) begin
    if (dm_we) begin
      for (int b = 0; b < 4; b++) begin
        if (dm_be[b]) mem[dm_addr][8*b +: 8] <= dm_wdata[8*b +: 8];
      end
    end
    if (poke_en) mem[poke_addr] <= poke_val;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Access size in bytes, 0 when the code performs no access.
  function automatic int model_size(input bit st, input logic [2:0] f3);
    int s;
    case (f3)
      3'd0:    s = 1;
      3'd1:    s = 2;
      3'd2:    s = 4;
      3'd4:    s = st ? 0 : 1;
      3'd5:    s = st ? 0 : 2;
      default: s = 0;
    endcase
    return s;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [7:0] a);
    int sz;
    logic [31:0] v;
    v  = 32'h0;
    sz = model_size(1'b0, f3);
    for (int i = 0; i < sz; i++) v[8*i +: 8] = ref_mem[(int'(a) + i) % 256];
    if (f3 == 3'd0) v = {{24{v[7]}}, v[7:0]};
    if (f3 == 3'd1) v = {{16{v[15]}}, v[15:0]};
    return v;
  endfunction

  function automatic logic [31:0] ref_word(input int w);
    logic [31:0] v;
    for (int b = 0; b < 4; b++) v[8*b +: 8] = ref_mem[(4*w + b) % 256];
    return v;
  endfunction

  task automatic poke(input int w, input logic [31:0] v);
    @(negedge clk);
    req_valid = 1'b0;
    poke_en   = 1'b1;
    poke_addr = w[5:0];
    poke_val  = v;
    @(posedge clk);
    #1;
    poke_en = 1'b0;
    for (int b = 0; b < 4; b++) ref_mem[4*w + b] = v[8*b +: 8];
  endtask

  task automatic set_req(input bit wr, input bit rd, input logic [2:0] f3,
                         input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    req_valid  = 1'b1;
    mem_write  = wr;
    mem_read   = rd;
    funct3     = f3;
    byte_addr  = a;
    store_data = d;
    #1;
  endtask

  task automatic do_idle();
    @(negedge clk);
    req_valid = 1'b0;
    mem_read  = 1'($urandom_range(0, 1));
    mem_write = 1'($urandom_range(0, 1));
    #1;
    check_eq("idle_enables", {28'h0, dm_we, dm_re, stall, |dm_be}, 32'h0);
    @(posedge clk);
    #1;
    check_eq("idle_load_valid", {31'h0, load_valid}, 32'h0);
    check_eq("idle_load_hold", load_data, last_ld);
  endtask

  task automatic do_access(input bit st, input logic [2:0] f3, input logic [7:0] a,
                           input logic [31:0] d);
    int sz;
    int stalls;
    bit cross_e;
    logic [31:0] exp;
    sz      = model_size(st, f3);
    cross_e = (sz != 0) && ((int'(a) % 4) + sz > 4);
    exp     = model_load(f3, a);
    set_req(st, st ? 1'($urandom_range(0, 1)) : 1'b1, f3, a, d);
    stalls = 0;
    while (stall === 1'b1 && stalls < 4) begin
      @(negedge clk);
      #1;
      stalls++;
    end
    check_eq("stall_cycles", stalls, cross_e ? 32'd1 : 32'd0);
    @(posedge clk);
    #1;
    check_eq("load_valid", {31'h0, load_valid}, {31'h0, !st});
    if (!st) begin
      check_eq("load_data", load_data, exp);
      last_ld = exp;
    end else begin
      for (int i = 0; i < sz; i++) ref_mem[(int'(a) + i) % 256] = d[8*i +: 8];
      check_eq("mem_word0", mem[a[7:2]], ref_word(int'(a[7:2])));
      check_eq("mem_word1", mem[6'(a[7:2] + 6'd1)], ref_word((int'(a[7:2]) + 1) % 64));
    end
  endtask

  initial begin
    n_cmp      = 0;
    n_bad      = 0;
    rst        = 1'b1;
    req_valid  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    funct3     = 3'd0;
    byte_addr  = 8'h00;
    store_data = 32'h0;
    poke_en    = 1'b0;
    poke_addr  = 6'd0;
    poke_val   = 32'h0;
    last_ld    = 32'h0;

    for (int w = 0; w < 64; w++) poke(w, $urandom);
    check_eq("rst_outputs", {28'h0, dm_we, dm_re, stall, load_valid}, 32'h0);
    check_eq("rst_be", {28'h0, dm_be}, 32'h0);
    check_eq("rst_load_data", load_data, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Aligned SW / LW at 0x0C
    set_req(1'b1, 1'b0, 3'b010, 8'h0C, 32'h0000_0022);
    check_eq("sw_addr", {26'h0, dm_addr}, 32'd3);
    check_eq("sw_be", {28'h0, dm_be}, 32'hF);
    check_eq("sw_we_stall", {30'h0, dm_we, stall}, 32'b10);
    set_req(1'b0, 1'b1, 3'b010, 8'h0C, 32'h0);
    @(posedge clk);
    #1;
    check_eq("lw_data", load_data, 32'h0000_0022);
    check_eq("lw_valid", {31'h0, load_valid}, 32'h1);

    // SB / LB / LBU at 0x0D
    set_req(1'b1, 1'b0, 3'b000, 8'h0D, 32'h0000_00AB);
    check_eq("sb_be", {28'h0, dm_be}, 32'b0010);
    check_eq("sb_wdata", dm_wdata, 32'h0000_AB00);
    set_req(1'b0, 1'b1, 3'b000, 8'h0D, 32'h0);
    @(posedge clk);
    #1;
    check_eq("lb_data", load_data, 32'hFFFF_FFAB);
    set_req(1'b0, 1'b1, 3'b100, 8'h0D, 32'h0);
    @(posedge clk);
    #1;
    check_eq("lbu_data", load_data, 32'h0000_00AB);

    // Crossing LH / LHU at 0x0F
    poke(3, 32'hAA00_0000);
    poke(4, 32'h0000_00BB);
    set_req(1'b0, 1'b1, 3'b001, 8'h0F, 32'h0);
    check_eq("lh_first", {25'h0, stall, dm_addr}, {25'h0, 1'b1, 6'd3});
    @(negedge clk);
    #1;
    check_eq("lh_second", {25'h0, stall, dm_addr}, {25'h0, 1'b0, 6'd4});
    check_eq("lh_no_early_valid", {31'h0, load_valid}, 32'h0);
    @(posedge clk);
    #1;
    check_eq("lh_data", load_data, 32'hFFFF_BBAA);
    check_eq("lh_valid", {31'h0, load_valid}, 32'h1);
    set_req(1'b0, 1'b1, 3'b101, 8'h0F, 32'h0);
    @(negedge clk);
    @(posedge clk);
    #1;
    check_eq("lhu_data", load_data, 32'h0000_BBAA);

    // Crossing SW at 0xFE wrapping to word 0
    set_req(1'b1, 1'b0, 3'b010, 8'hFE, 32'h1122_3344);
    check_eq("swx_first", {22'h0, dm_addr, dm_be}, {22'h0, 6'd63, 4'b1100});
    check_eq("swx_first_wdata", dm_wdata, 32'h3344_0000);
    check_eq("swx_first_stall", {31'h0, stall}, 32'h1);
    @(negedge clk);
    #1;
    check_eq("swx_second", {22'h0, dm_addr, dm_be}, {22'h0, 6'd0, 4'b0011});
    check_eq("swx_second_wdata", dm_wdata, 32'h0000_1122);
    check_eq("swx_second_ctl", {30'h0, dm_we, stall}, 32'b10);

    // Undefined width code 011
    set_req(1'b0, 1'b1, 3'b011, 8'h10, 32'h0);
    @(posedge clk);
    #1;
    check_eq("f3_011_ld_data", load_data, 32'h0);
    check_eq("f3_011_ld_valid", {31'h0, load_valid}, 32'h1);
    set_req(1'b1, 1'b0, 3'b011, 8'h10, 32'hDEAD_BEEF);
    check_eq("f3_011_st_we", {30'h0, dm_we, stall}, 32'h0);

    // Reset in SECOND of a crossing LW
    set_req(1'b0, 1'b1, 3'b010, 8'h0C, 32'h0);
    @(posedge clk);
    #1;
    check_eq("pre_rst_lw", load_data, 32'hAA00_0000);
    set_req(1'b0, 1'b1, 3'b010, 8'h05, 32'h0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_eq("rst_second_ctl", {29'h0, stall, load_valid, dm_re}, 32'h0);
    check_eq("rst_second_data", load_data, 32'h0);
    @(negedge clk);
    req_valid = 1'b0;
    rst       = 1'b0;
    last_ld   = 32'h0;

    // Resynchronise memory and reference, then random traffic
    for (int w = 0; w < 64; w++) poke(w, $urandom);
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        do_idle();
      end else begin
        do_access(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                  8'($urandom_range(0, 255)), $urandom);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lsu_align_unit.md
Name: lsu_align_unit

Overview:
- Load/store alignment unit between the EX/MEM pipeline register and the word-organised data memory (64 x 32-bit, word-addressed).
- Converts byte addresses into word address, byte enables and lane-shifted write data, and sign/zero-extends load results.
- Splits accesses that cross a word boundary into two word accesses and stalls the pipeline for the extra cycle.
- Load results are registered into the MEM/WB boundary.

Parameters:
- ADDR_W, 8, byte-address width (256 B = 64 words)
- WORD_AW, 6, word-address width (ADDR_W-2)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- req_valid  in  1  MEM-stage instruction valid
- mem_read  in  1  load request
- mem_write  in  1  store request (mem_read and mem_write both high: store wins)
- funct3  in  3  RV32I width/sign code
- byte_addr  in  ADDR_W  effective byte address
- store_data  in  32  rs2 value
- dm_addr  out  WORD_AW  word address to memory
- dm_re  out  1  memory read enable
- dm_we  out  1  memory write enable
- dm_be  out  4  byte-lane write enables
- dm_wdata  out  32  lane-aligned write data
- dm_rdata  in  32  combinational read data (same cycle as dm_addr)
- stall  out  1  hold IF/ID/EX and the EX/MEM register
- load_data  out  32  registered, extended load result
- load_valid  out  1  registered; load_data valid this cycle

Behaviour:
- Reset: state=IDLE; load_data=0; load_valid=0; lo_hold=0; stall=0; dm_re/dm_we/dm_be all 0. Async assert; release is sampled on clk.
- off = byte_addr[1:0]; w0 = byte_addr[7:2]; w1 = w0+1 mod 64 (word 63 wraps to word 0).
- Crossing access: funct3 001/101 with off=3, or funct3 010 with off!=0. Byte accesses never cross.
- States: IDLE, SECOND.
- IDLE, non-crossing access (req_valid and an access requested):
  - dm_addr=w0; stall=0.
  - Store (funct3 000/001/010):
    - dm_we=1.
    - dm_be = {0001, 0011, 1111}[width] << off.
    - dm_wdata = store_data << 8*off.
  - Store with funct3 011/1xx: dm_we=0, no write.
  - Load: dm_re=1; shift dm_rdata >> 8*off, then extend per funct3.
    - 000 LB: sign-extend byte.
    - 001 LH: sign-extend halfword.
    - 010 LW: full word.
    - 100 LBU: zero-extend byte.
    - 101 LHU: zero-extend halfword.
    - Other codes: result 0.
  - Result registered: load_data and load_valid=1 on the next edge.
- IDLE, crossing access:
  - stall=1 combinationally; dm_addr=w0.
  - Store: dm_be = (lane mask << off)[3:0]; write occurs this edge.
  - Load: dm_rdata upper lanes captured into lo_hold.
  - Next state SECOND. No load_valid this cycle.
- SECOND:
  - stall=0; dm_addr=w1.
  - Store: dm_be = mask bits shifted out of the first word; dm_wdata carries the remaining bytes in lanes from 0.
  - Load: merge lo_hold with low lanes of dm_rdata, extend, register; load_valid=1 next edge.
  - Next state IDLE.
- Upstream must hold the request stable while stall=1. Any change to the request in SECOND is a protocol violation; the unit uses the live inputs.
- No request (req_valid=0) in IDLE: all dm_* enables 0; load_valid=0 next edge; load_data holds its value.
- rst during SECOND: abandon the split and return to IDLE. The first-half store write is already committed and is not rolled back.
- Throughput: one access per cycle for non-crossing accesses; crossing accesses take 2 cycles.

Optional Feature:
- LSU_MISALIGN_TRAP_EN defined:
  - No splitting; SECOND state is not built.
  - A crossing access asserts extra output misalign_trap (1 bit, registered, pulses 1 cycle).
  - The store is suppressed (dm_we=0); no load_valid; stall never asserted.
- Undefined: split behaviour as above; the misalign_trap port does not exist.

Decomposition:
- Shared package lsu_pkg holds:
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - State encoding IDLE/SECOND.
  - Function lane_mask(funct3) returning 4 bits.
- One natural sub-module: load_extend (combinational shift/merge plus sign/zero extension), instantiated once.

Test Plan:
- Aligned SW at byte_addr 0x0C, data 0x00000022 -> dm_addr=3, dm_be=1111, dm_we=1, stall=0. LW 0x0C with dm_rdata=0x22 -> load_data=0x00000022, load_valid next cycle.
- SB 0xAB at byte_addr 0x0D -> dm_be=0010, dm_wdata=0x0000AB00. LB from 0x0D with word 0x0000AB00 -> 0xFFFFFFAB; LBU -> 0x000000AB.
- LH at 0x0F, word3=0xAA000000, word4=0x000000BB -> stall 1 cycle, dm_addr 3 then 4, load_data=0xFFFFBBAA. LHU -> 0x0000BBAA.
- SW 0x11223344 at 0xFE -> cycle1: addr 63, be=1100, wdata=0x33440000; cycle2: addr 0 (wrap), be=0011, wdata=0x00001122.
- rst asserted in SECOND of a crossing LW -> state IDLE, stall=0, load_valid=0, load_data=0 immediately.
- funct3=011 load at 0x10 -> load_data=0, load_valid=1. funct3=011 store -> dm_we=0.
